instr_encoder_loader: RTL and testbench

Inverse of the main instruction decoder. Accepts mnemonic-level instructions over a valid/ready handshake and encodes each into a 32-bit machine word using the field layout the decoder consumes: cond, Op, Funct, Rn, Rd, Src2. Writes the words sequentially into instruction memory with an auto-incrementing word address. Used as the program loader in front of the single-cycle processor.

---
 rtl/instr_encoder_loader_pkg.sv | 45 ++++
 rtl/instr_encoder_loader_if.sv | 29 ++
 rtl/instr_encoder_loader_field_encoder.sv | 64 ++++++
 rtl/instr_encoder_loader.sv | 141 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants for the instruction loader and the main decoder.
// Holds mnemonic codes, ALU cmd codes, fixed opcode/cond fields, the
// Funct encodings of the non-ALU forms, and the loader state encoding.
package instr_encoder_loader_pkg;

    typedef enum logic [3:0] {
        MN_ADD = 4'd0,
        MN_SUB = 4'd1,
        MN_AND = 4'd2,
        MN_ORR = 4'd3,
        MN_CMP = 4'd4,
        MN_LSL = 4'd5,
        MN_LSR = 4'd6,
        MN_LDR = 4'd7,
        MN_STR = 4'd8
    } mnemonic_e;

    // ALU cmd codes, shared with the decoder
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [1:0] OP_DP   = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b01;

    localparam logic [5:0] FUNCT_LSL = 6'b110000;
    localparam logic [5:0] FUNCT_LSR = 6'b100010;
    localparam logic [5:0] FUNCT_LDR = 6'b011001;
    localparam logic [5:0] FUNCT_STR = 6'b011000;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_FULL  = 3'd4
    } state_e;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Loader bus: instruction-field handshake in, instruction-memory write out.
// master = instruction source + memory side (testbench), slave = loader.
//   InValid/InReady    : field handshake
//   Mnemonic/Rd/Rn/Rm/Imm : mnemonic-level instruction fields
//   InstrWE/InstrAddr/InstrWord : memory write port
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 6
);
    logic              InValid;
    logic              InReady;
    logic [3:0]        Mnemonic;
    logic [3:0]        Rd;
    logic [3:0]        Rn;
    logic [3:0]        Rm;
    logic [11:0]       Imm;
    logic              InstrWE;
    logic [ADDR_W-1:0] InstrAddr;
    logic [31:0]       InstrWord;

    modport master (
        output InValid, Mnemonic, Rd, Rn, Rm, Imm,
        input  InReady, InstrWE, InstrAddr, InstrWord
    );

    modport slave (
        input  InValid, Mnemonic, Rd, Rn, Rm, Imm,
        output InReady, InstrWE, InstrAddr, InstrWord
    );
endinterface

// File: rtl/instr_encoder_loader_field_encoder.sv
// instr_field_encoder: combinational mnemonic -> 32-bit machine word.
// Layout: {cond, Op, Funct, Rn, Rd, Src2}.
//   Mnemonic, Rd, Rn, Rm, Imm : instruction fields
//   Word    : encoded word (zero when illegal)
//   Illegal : mnemonic code 9..15
module instr_field_encoder
    import instr_encoder_loader_pkg::*;
(
    input  logic [3:0]  Mnemonic,
    input  logic [3:0]  Rd,
    input  logic [3:0]  Rn,
    input  logic [3:0]  Rm,
    input  logic [11:0] Imm,
    output logic [31:0] Word,
    output logic        Illegal
);
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn_f;
    logic [3:0]  rd_f;
    logic [11:0] src2;

    always_comb begin
        op      = OP_DP;
        funct   = '0;
        rn_f    = Rn;
        rd_f    = Rd;
        src2    = {8'h00, Rm};
        Illegal = 1'b0;
        case (Mnemonic)
            MN_ADD: funct = {1'b0, CMD_ADD, 1'b0};
            MN_SUB: funct = {1'b0, CMD_SUB, 1'b0};
            MN_AND: funct = {1'b0, CMD_AND, 1'b0};
            MN_ORR: funct = {1'b0, CMD_ORR, 1'b0};
            MN_CMP: begin
                // compare only sets flags: S=1, no destination
                funct = {1'b0, CMD_CMP, 1'b1};
                rd_f  = '0;
            end
            MN_LSL: begin
                funct = FUNCT_LSL;
                rn_f  = '0;
                src2  = {Imm[4:0], SH_LSL, 1'b0, Rm};
            end
            MN_LSR: begin
                funct = FUNCT_LSR;
                rn_f  = '0;
                src2  = {Imm[4:0], SH_LSR, 1'b0, Rm};
            end
            MN_LDR: begin
                op    = OP_MEM;
                funct = FUNCT_LDR;
                src2  = Imm;
            end
            MN_STR: begin
                op    = OP_MEM;
                funct = FUNCT_STR;
                src2  = Imm;
            end
            default: Illegal = 1'b1;
        endcase
        Word = Illegal ? 32'h0 : {COND_AL, op, funct, rn_f, rd_f, src2};
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes mnemonic-level instructions and writes them to
// instruction memory at sequential word addresses.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   Start      : begin a new session at address 0 (from IDLE/DONE/FULL)
//   Finish     : end the session early (honoured in LOAD only)
//   bus        : field handshake + memory write port (slave side)
//   Count      : words written this session
//   Busy/Done  : session active / session ended
//   Err        : sticky illegal-mnemonic flag for this session
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Start,
    input  logic                   Finish,
    instr_encoder_loader_if.slave  bus,
    output logic [ADDR_W:0]        Count,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Err
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [31:0] enc_word;
    logic        enc_illegal;

    instr_field_encoder u_enc (
        .Mnemonic (bus.Mnemonic),
        .Rd       (bus.Rd),
        .Rn       (bus.Rn),
        .Rm       (bus.Rm),
        .Imm      (bus.Imm),
        .Word     (enc_word),
        .Illegal  (enc_illegal)
    );

    state_e            state_q,    state_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [31:0]       word_q,     word_d;
    logic [ADDR_W:0]   count_q,    count_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;

    // All outputs are registered alongside the state so that they always
    // describe the state being occupied this cycle.
    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        word_d     = word_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        case (state_q)
            ST_LOAD: begin
                if (Finish) begin
                    // any simultaneous handshake is dropped
                    state_d    = ST_DONE;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end else if (bus.InValid && in_ready_q) begin
                    if (enc_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = ST_WRITE;
                        word_d     = enc_word;
                        we_d       = 1'b1;
                        in_ready_d = 1'b0;
                    end
                end
            end
            ST_WRITE: begin
                // address wraps naturally only when DEPTH == 2**ADDR_W
                addr_d  = addr_q + 1'b1;
                count_d = count_q + 1'b1;
                if (count_d == DEPTH_C) begin
                    state_d = ST_FULL;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d    = ST_LOAD;
                    in_ready_d = 1'b1;
                end
            end
            default: begin // IDLE, DONE, FULL
                if (Start) begin
                    state_d    = ST_LOAD;
                    in_ready_d = 1'b1;
                    addr_d     = '0;
                    count_d    = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            word_q     <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.InReady   = in_ready_q;
    assign bus.InstrWE   = we_q;
    assign bus.InstrAddr = addr_q;
    assign bus.InstrWord = word_q;
    assign Count         = count_q;
    assign Busy          = busy_q;
    assign Done          = done_q;
    assign Err           = err_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (ADDR_W=6, DEPTH=4).
module tb_instr_encoder_loader;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset, Start, Finish;
    logic [ADDR_W:0] Count;
    logic Busy, Done, Err;
    int n_cmp = 0;
    int n_err = 0;

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .Finish (Finish),
        .bus    (bus),
        .Count  (Count),
        .Busy   (Busy),
        .Done   (Done),
        .Err    (Err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [3:0] m, input logic [3:0] rd, input logic [3:0] rn,
                              input logic [3:0] rm, input logic [11:0] imm);
        bus.Mnemonic = m;
        bus.Rd       = rd;
        bus.Rn       = rn;
        bus.Rm       = rm;
        bus.Imm      = imm;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    // One legal instruction: handshake, check the write cycle, then the
    // cycle after it (address/count advanced).
    task automatic send(input string tag, input logic [3:0] m, input logic [3:0] rd,
                        input logic [3:0] rn, input logic [3:0] rm, input logic [11:0] imm,
                        input logic [31:0] exp_word, input int exp_addr);
        int n;
        n = 0;
        while (bus.InReady !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_ready"}, bus.InReady, 1);
        set_fields(m, rd, rn, rm, imm);
        bus.InValid = 1'b1;
        step();
        bus.InValid = 1'b0;
        chk({tag, "_we"}, bus.InstrWE, 1);
        chk({tag, "_addr"}, bus.InstrAddr, exp_addr);
        chk({tag, "_word"}, bus.InstrWord, exp_word);
        chk({tag, "_notready"}, bus.InReady, 0);
        step();
        chk({tag, "_we_off"}, bus.InstrWE, 0);
        chk({tag, "_count"}, Count, exp_addr + 1);
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; Finish = 1'b0;
        bus.InValid = 1'b0;
        set_fields(4'd0, 4'd0, 4'd0, 4'd0, 12'd0);
        step(); step();
        chk("rst_ready", bus.InReady, 0);
        chk("rst_we", bus.InstrWE, 0);
        chk("rst_addr", bus.InstrAddr, 0);
        chk("rst_word", bus.InstrWord, 0);
        chk("rst_count", Count, 0);
        chk("rst_flags", {Busy, Done, Err}, 3'b000);
        reset = 1'b0;
        step();
        chk("idle_ready", bus.InReady, 0);

        // Session 1: ADD, illegal, LSL, LSR, then Finish with a handshake
        pulse_start();
        chk("s1_busy", {Busy, Done, bus.InReady}, 3'b101);
        send("add", 4'd0, 4'd1, 4'd2, 4'd3, 12'd0, 32'hE0821003, 0);
        Start = 1'b1;            // ignored in LOAD
        step();
        Start = 1'b0;
        chk("start_in_load_count", Count, 1);
        chk("start_in_load_ready", bus.InReady, 1);
        set_fields(4'd12, 4'd1, 4'd2, 4'd3, 12'd0);
        bus.InValid = 1'b1;
        step();
        bus.InValid = 1'b0;
        chk("illegal_we", bus.InstrWE, 0);
        chk("illegal_err", Err, 1);
        chk("illegal_count", Count, 1);
        chk("illegal_ready", bus.InReady, 1);
        send("lsl", 4'd5, 4'd1, 4'd0, 4'd2, 12'd3, 32'hE3001182, 1);
        chk("err_sticky", Err, 1);
        send("lsr", 4'd6, 4'd1, 4'd0, 4'd2, 12'd3, 32'hE22011A2, 2);
        set_fields(4'd0, 4'd1, 4'd2, 4'd3, 12'd0);
        bus.InValid = 1'b1;
        Finish = 1'b1;
        step();
        bus.InValid = 1'b0;
        Finish = 1'b0;
        chk("finish_we", bus.InstrWE, 0);
        chk("finish_flags", {Busy, Done, bus.InReady}, 3'b010);
        step();
        chk("finish_we2", bus.InstrWE, 0);
        chk("finish_count", Count, 3);

        // Session 2: restart from DONE, stream to FULL
        pulse_start();
        chk("s2_count", Count, 0);
        chk("s2_err_clear", Err, 0);
        chk("s2_addr", bus.InstrAddr, 0);
        set_fields(4'd15, 4'd0, 4'd0, 4'd0, 12'd0);
        bus.InValid = 1'b1;
        step();
        bus.InValid = 1'b0;
        chk("s2_err", Err, 1);
        send("sub", 4'd1, 4'd4, 4'd5, 4'd6, 12'd0, 32'hE0454006, 0);
        send("cmp", 4'd4, 4'd0, 4'd1, 4'd2, 12'd0, 32'hE1510002, 1);
        send("ldr", 4'd7, 4'd0, 4'd1, 4'd0, 12'd8, 32'hE5910008, 2);
        send("str", 4'd8, 4'd2, 4'd3, 4'd0, 12'd4, 32'hE5832004, 3);
        chk("full_flags", {Busy, Done, bus.InReady}, 3'b010);
        chk("full_addr", bus.InstrAddr, 4);
        set_fields(4'd0, 4'd1, 4'd2, 4'd3, 12'd0);
        bus.InValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_no_write", bus.InstrWE, 0);
        end
        bus.InValid = 1'b0;
        chk("full_count", Count, 4);

        // Restart from FULL
        pulse_start();
        chk("s3_flags", {Busy, Done, Err, bus.InReady}, 4'b1001);
        chk("s3_count", Count, 0);
        send("add2", 4'd0, 4'd1, 4'd2, 4'd3, 12'd0, 32'hE0821003, 0);

        // Reset during WRITE
        set_fields(4'd3, 4'd7, 4'd8, 4'd9, 12'd0);
        bus.InValid = 1'b1;
        step();
        bus.InValid = 1'b0;
        chk("orr_we", bus.InstrWE, 1);
        chk("orr_word", bus.InstrWord, 32'hE1887009);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_we", bus.InstrWE, 0);
        chk("rst2_addr", bus.InstrAddr, 0);
        chk("rst2_word", bus.InstrWord, 0);
        chk("rst2_count", Count, 0);
        chk("rst2_flags", {Busy, Done, Err, bus.InReady}, 4'b0000);
        step();
        chk("rst2_idle_we", bus.InstrWE, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
